// File: rtl/panel_pkg.sv
// Shared panel constants: geometry, RGB565 field layout and the arbiter state type.
package panel_pkg;

  localparam int unsigned PANEL_WIDTH  = 64;
  localparam int unsigned PANEL_HEIGHT = 32;
  localparam int unsigned PIXEL_COUNT  = PANEL_WIDTH * PANEL_HEIGHT;

  localparam int unsigned PIXEL_W   = 16;
  localparam int unsigned RED_LSB   = 0;
  localparam int unsigned GREEN_LSB = 5;
  localparam int unsigned BLUE_LSB  = 11;
  localparam int unsigned RED_W     = GREEN_LSB - RED_LSB;
  localparam int unsigned GREEN_W   = BLUE_LSB - GREEN_LSB;
  localparam int unsigned BLUE_W    = PIXEL_W - BLUE_LSB;

  typedef struct packed {
    logic [BLUE_W-1:0]  blue;
    logic [GREEN_W-1:0] green;
    logic [RED_W-1:0]   red;
  } pixel_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/panel_wr_arbiter_if.sv
// Requester burst handshake plus the panel write port, shared by requesters and arbiter.
interface panel_wr_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      ctrl_en;
  logic [ADDR_W-1:0]         ctrl_addr;
  logic [DATA_W-1:0]         ctrl_wdat;

  modport master (
    output req_valid, req_last, req_addr, req_data,
    input  req_ready, ctrl_en, ctrl_addr, ctrl_wdat
  );

  modport slave (
    input  req_valid, req_last, req_addr, req_data,
    output req_ready, ctrl_en, ctrl_addr, ctrl_wdat
  );
endinterface

// File: rtl/panel_wr_arbiter_rr_pick.sv
// Rotating-priority encoder: first set request after last_owner, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_owner,
  output logic                       found,
  output logic [$clog2(NUM_REQ)-1:0] index
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  always_comb begin
    found = 1'b0;
    index = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      if (!found && req[ID_W'((int'(last_owner) + k) % int'(NUM_REQ))]) begin
        found = 1'b1;
        index = ID_W'((int'(last_owner) + k) % int'(NUM_REQ));
      end
    end
  end
endmodule

// File: rtl/panel_wr_arbiter.sv
// Round-robin burst arbiter for the panel video-memory write port.
// Define PANEL_ARB_STATS_EN to add saturating beat/drop/timeout statistics outputs.
module panel_wr_arbiter #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned PIXEL_COUNT  = panel_pkg::PIXEL_COUNT,
  parameter int unsigned MAX_BURST    = 64,
  parameter int unsigned IDLE_TIMEOUT = 16
) (
  input  logic                       display_clock,
  input  logic                       reset,
  panel_wr_arbiter_if.slave          bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       drop_pulse
`ifdef PANEL_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]      stat_beats,
  output logic [31:0]                stat_drops,
  output logic [NUM_REQ*16-1:0]      stat_timeouts
`endif
);
  import panel_pkg::*;

  localparam int unsigned ID_W    = $clog2(NUM_REQ);
  localparam int unsigned BEAT_W  = $clog2(MAX_BURST + 1);
  localparam int unsigned STALL_W = $clog2(IDLE_TIMEOUT + 1);
  localparam int unsigned LIM_W   = ADDR_W + 1;
  localparam logic [LIM_W-1:0] ADDR_LIM = LIM_W'(PIXEL_COUNT);

  arb_state_t          state_q, state_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [ID_W-1:0]     last_owner_q, last_owner_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic                ctrl_en_q, ctrl_en_d;
  logic [ADDR_W-1:0]   ctrl_addr_q, ctrl_addr_d;
  logic [DATA_W-1:0]   ctrl_wdat_q, ctrl_wdat_d;
  logic                drop_q, drop_d;

  logic                pick_found_c;
  logic [ID_W-1:0]     pick_idx_c;
  logic [NUM_REQ-1:0]  ready_c;
  logic                own_valid_c, own_last_c;
  logic [ADDR_W-1:0]   own_addr_c;
  logic [DATA_W-1:0]   own_data_c;
  logic                xfer_c, addr_ok_c, timeout_c;
  logic [BEAT_W-1:0]   beat_inc_c;
  logic [STALL_W-1:0]  stall_inc_c;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req        (bus.req_valid),
    .last_owner (last_owner_q),
    .found      (pick_found_c),
    .index      (pick_idx_c)
  );

  // Owner's lane of the packed request buses; everyone else is ignored.
  always_comb begin
    own_valid_c = 1'b0;
    own_last_c  = 1'b0;
    own_addr_c  = '0;
    own_data_c  = '0;
    ready_c     = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (ID_W'(i) == owner_q) begin
        own_valid_c = bus.req_valid[i];
        own_last_c  = bus.req_last[i];
        own_addr_c  = bus.req_addr[i*ADDR_W +: ADDR_W];
        own_data_c  = bus.req_data[i*DATA_W +: DATA_W];
        ready_c[i]  = (state_q == ST_BURST);
      end
    end
    xfer_c      = (state_q == ST_BURST) && own_valid_c;
    addr_ok_c   = {1'b0, own_addr_c} < ADDR_LIM;
    beat_inc_c  = beat_cnt_q + BEAT_W'(1);
    stall_inc_c = (stall_cnt_q == STALL_W'(IDLE_TIMEOUT)) ? stall_cnt_q
                                                          : stall_cnt_q + STALL_W'(1);
    timeout_c   = (state_q == ST_BURST) && !own_valid_c
                  && (stall_inc_c == STALL_W'(IDLE_TIMEOUT));
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    grant_id_d   = grant_id_q;
    beat_cnt_d   = beat_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    ctrl_en_d    = 1'b0;
    ctrl_addr_d  = ctrl_addr_q;
    ctrl_wdat_d  = ctrl_wdat_q;
    drop_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found_c) begin
          state_d     = ST_BURST;
          owner_d     = pick_idx_c;
          grant_id_d  = pick_idx_c;
          beat_cnt_d  = '0;
          stall_cnt_d = '0;
        end
      end
      ST_BURST: begin
        if (xfer_c) begin
          beat_cnt_d  = beat_inc_c;
          stall_cnt_d = '0;
          if (addr_ok_c) begin
            ctrl_en_d   = 1'b1;
            ctrl_addr_d = own_addr_c;
            ctrl_wdat_d = own_data_c;
          end else begin
            drop_d = 1'b1;
          end
          if (own_last_c || (beat_inc_c == BEAT_W'(MAX_BURST))) begin
            state_d      = ST_IDLE;
            last_owner_d = owner_q;
          end
        end else begin
          stall_cnt_d = stall_inc_c;
          if (timeout_c) begin
            state_d      = ST_IDLE;
            last_owner_d = owner_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge display_clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_owner_q <= ID_W'(NUM_REQ - 1);
      grant_id_q   <= '0;
      beat_cnt_q   <= '0;
      stall_cnt_q  <= '0;
      ctrl_en_q    <= 1'b0;
      ctrl_addr_q  <= '0;
      ctrl_wdat_q  <= '0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      grant_id_q   <= grant_id_d;
      beat_cnt_q   <= beat_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      ctrl_en_q    <= ctrl_en_d;
      ctrl_addr_q  <= ctrl_addr_d;
      ctrl_wdat_q  <= ctrl_wdat_d;
      drop_q       <= drop_d;
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.ctrl_en   = ctrl_en_q;
  assign bus.ctrl_addr = ctrl_addr_q;
  assign bus.ctrl_wdat = ctrl_wdat_q;
  assign grant_id      = grant_id_q;
  assign drop_pulse    = drop_q;

`ifdef PANEL_ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0] stat_beats_q, stat_beats_d;
  logic [31:0]              stat_drops_q, stat_drops_d;
  logic [NUM_REQ-1:0][15:0] stat_timeouts_q, stat_timeouts_d;

  // Saturating counters, attributed to the current owner.
  always_comb begin
    stat_beats_d    = stat_beats_q;
    stat_drops_d    = stat_drops_q;
    stat_timeouts_d = stat_timeouts_q;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (ID_W'(i) == owner_q) begin
        if (xfer_c && (stat_beats_q[i] != '1)) stat_beats_d[i] = stat_beats_q[i] + 32'd1;
        if (timeout_c && (stat_timeouts_q[i] != '1)) stat_timeouts_d[i] = stat_timeouts_q[i] + 16'd1;
      end
    end
    if (xfer_c && !addr_ok_c && (stat_drops_q != '1)) stat_drops_d = stat_drops_q + 32'd1;
  end

  always_ff @(posedge display_clock) begin
    if (reset) begin
      stat_beats_q    <= '0;
      stat_drops_q    <= '0;
      stat_timeouts_q <= '0;
    end else begin
      stat_beats_q    <= stat_beats_d;
      stat_drops_q    <= stat_drops_d;
      stat_timeouts_q <= stat_timeouts_d;
    end
  end

  assign stat_beats    = stat_beats_q;
  assign stat_drops    = stat_drops_q;
  assign stat_timeouts = stat_timeouts_q;
`endif
endmodule

// File: tb/tb_panel_wr_arbiter.sv
// Directed bench for panel_wr_arbiter: vector table plus burst, contention, cut, timeout and reset sequences.
module tb_panel_wr_arbiter;
  import panel_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  panel_wr_arbiter_if #(.NUM_REQ(2), .ADDR_W(16), .DATA_W(16)) bus ();
  logic [0:0] grant_id;
  logic       drop_pulse;
`ifdef PANEL_ARB_STATS_EN
  logic [63:0] stat_beats;
  logic [31:0] stat_drops;
  logic [31:0] stat_timeouts;
`endif

  panel_wr_arbiter #(
    .NUM_REQ(2), .ADDR_W(16), .DATA_W(16), .PIXEL_COUNT(2048),
    .MAX_BURST(64), .IDLE_TIMEOUT(16)
  ) dut (
    .display_clock (clk),
    .reset         (reset),
    .bus           (bus),
    .grant_id      (grant_id),
    .drop_pulse    (drop_pulse)
`ifdef PANEL_ARB_STATS_EN
    ,
    .stat_beats    (stat_beats),
    .stat_drops    (stat_drops),
    .stat_timeouts (stat_timeouts)
`endif
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] l,
                       input logic [15:0] a0, input logic [15:0] d0,
                       input logic [15:0] a1, input logic [15:0] d1);
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_addr  = {a1, a0};
    bus.req_data  = {d1, d0};
  endtask

  // Ends on a negedge with reset just released and the DUT in IDLE.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [1:0]  l;
    logic [15:0] a0, d0, a1, d1;
    logic [1:0]  e_rdy;
    logic        e_en;
    logic [15:0] e_addr, e_wdat;
    logic        e_gid;
    logic        e_drop;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt[2];
    logic [1:0] exp_rdy;
    logic prev_x;
    logic [15:0] prev_a;
    logic [15:0] a;
    int stall;
    int guard;
    int r;

    // Each row: inputs driven in that cycle, outputs expected in that same cycle.
    vecs[0]  = '{2'b01, 2'b00, 16'h0005, 16'hAAAA, 16'h0000, 16'h0000, 2'b00, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{2'b01, 2'b00, 16'h0005, 16'hAAAA, 16'h0000, 16'h0000, 2'b01, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[2]  = '{2'b11, 2'b10, 16'h0800, 16'h1234, 16'h0007, 16'h7777, 2'b01, 1'b1, 16'h0005, 16'hAAAA, 1'b0, 1'b0};
    vecs[3]  = '{2'b01, 2'b01, 16'h0009, 16'h0909, 16'h0000, 16'h0000, 2'b01, 1'b0, 16'h0005, 16'hAAAA, 1'b0, 1'b1};
    vecs[4]  = '{2'b11, 2'b11, 16'h000A, 16'h0A0A, 16'h0007, 16'h7777, 2'b00, 1'b1, 16'h0009, 16'h0909, 1'b0, 1'b0};
    vecs[5]  = '{2'b11, 2'b11, 16'h000A, 16'h0A0A, 16'h0007, 16'h7777, 2'b10, 1'b0, 16'h0009, 16'h0909, 1'b1, 1'b0};
    vecs[6]  = '{2'b01, 2'b01, 16'h000A, 16'h0A0A, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0007, 16'h7777, 1'b1, 1'b0};
    vecs[7]  = '{2'b01, 2'b01, 16'h000A, 16'h0A0A, 16'h0000, 16'h0000, 2'b01, 1'b0, 16'h0007, 16'h7777, 1'b0, 1'b0};
    vecs[8]  = '{2'b01, 2'b01, 16'h000B, 16'h0B0B, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h000A, 16'h0A0A, 1'b0, 1'b0};
    vecs[9]  = '{2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b01, 1'b0, 16'h000A, 16'h0A0A, 1'b0, 1'b0};
    vecs[10] = '{2'b01, 2'b01, 16'h000B, 16'h0B0B, 16'h0000, 16'h0000, 2'b01, 1'b0, 16'h000A, 16'h0A0A, 1'b0, 1'b0};
    vecs[11] = '{2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h000B, 16'h0B0B, 1'b0, 1'b0};
    vecs[12] = '{2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 1'b0, 16'h000B, 16'h0B0B, 1'b0, 1'b0};

    reset = 1'b1;
    drive(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    @(negedge clk);

    for (int k = 0; k < 13; k++) begin
      chk($sformatf("vec%0d_ready", k), 32'(bus.req_ready), 32'(vecs[k].e_rdy));
      chk($sformatf("vec%0d_en", k),    32'(bus.ctrl_en),   32'(vecs[k].e_en));
      chk($sformatf("vec%0d_addr", k),  32'(bus.ctrl_addr), 32'(vecs[k].e_addr));
      chk($sformatf("vec%0d_wdat", k),  32'(bus.ctrl_wdat), 32'(vecs[k].e_wdat));
      chk($sformatf("vec%0d_gid", k),   32'(grant_id),      32'(vecs[k].e_gid));
      chk($sformatf("vec%0d_drop", k),  32'(drop_pulse),    32'(vecs[k].e_drop));
      reset = 1'b0;
      drive(vecs[k].v, vecs[k].l, vecs[k].a0, vecs[k].d0, vecs[k].a1, vecs[k].d1);
      @(negedge clk);
    end
`ifdef PANEL_ARB_STATS_EN
    chk("stat_drops", stat_drops, 32'd1);
`endif

    // Single 64-beat burst from requester 0.
    do_reset();
    drive(2'b01, 2'b00, 16'd0, 16'd0, 16'd0, 16'd0);
    @(negedge clk);
    chk("sb_grant", 32'(bus.req_ready), 32'h1);
    for (int i = 0; i < 64; i++) begin
      drive(2'b01, (i == 63) ? 2'b01 : 2'b00, 16'(i), 16'(i), 16'd0, 16'd0);
      @(negedge clk);
      chk($sformatf("sb_en%0d", i),   32'(bus.ctrl_en),   32'h1);
      chk($sformatf("sb_addr%0d", i), 32'(bus.ctrl_addr), 32'(i));
      chk($sformatf("sb_wdat%0d", i), 32'(bus.ctrl_wdat), 32'(i));
      chk($sformatf("sb_rdy%0d", i),  32'(bus.req_ready), (i == 63) ? 32'h0 : 32'h1);
    end
    drive(2'b00, 2'b00, 16'd0, 16'd0, 16'd0, 16'd0);
    @(negedge clk);
    chk("sb_en_after", 32'(bus.ctrl_en), 32'h0);
    chk("sb_rdy_after", 32'(bus.req_ready), 32'h0);

    // Contention with 4-beat bursts: 0,1,0,1 with one IDLE cycle between bursts.
    do_reset();
    cnt[0] = 0;
    cnt[1] = 0;
    prev_x = 1'b0;
    prev_a = '0;
    for (int c = 0; c < 21; c++) begin
      exp_rdy = (c % 5 == 0) ? 2'b00 : (((c / 5) % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("ct_rdy%0d", c), 32'(bus.req_ready), 32'(exp_rdy));
      chk($sformatf("ct_en%0d", c), 32'(bus.ctrl_en), 32'(prev_x));
      if (prev_x) chk($sformatf("ct_addr%0d", c), 32'(bus.ctrl_addr), 32'(prev_a));
      drive(2'b11, {(cnt[1] % 4 == 3), (cnt[0] % 4 == 3)},
            16'(cnt[0]), 16'(cnt[0]), 16'(256 + cnt[1]), 16'(256 + cnt[1]));
      prev_x = (exp_rdy != 2'b00);
      if (prev_x) begin
        r = exp_rdy[1] ? 1 : 0;
        prev_a = 16'(r * 256 + cnt[r]);
        cnt[r]++;
      end
      @(negedge clk);
    end

    // MAX_BURST cut: requester 1 streams 100 beats without last while requester 0 waits.
    do_reset();
    drive(2'b10, 2'b00, 16'd0, 16'd0, 16'd100, 16'd100);
    @(negedge clk);
    chk("cut_grant1", 32'(bus.req_ready), 32'h2);
    for (int b = 0; b < 64; b++) begin
      drive(2'b11, 2'b01, 16'd500, 16'd500, 16'(100 + b), 16'(100 + b));
      @(negedge clk);
      chk($sformatf("cut_rdy%0d", b), 32'(bus.req_ready), (b == 63) ? 32'h0 : 32'h2);
      chk($sformatf("cut_addr%0d", b), 32'(bus.ctrl_addr), 32'(100 + b));
    end
    chk("cut_en_last", 32'(bus.ctrl_en), 32'h1);
    drive(2'b11, 2'b01, 16'd500, 16'd500, 16'd164, 16'd164);
    @(negedge clk);
    chk("cut_grant0", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    chk("cut_idle2", 32'(bus.req_ready), 32'h0);
    chk("cut_addr0", 32'(bus.ctrl_addr), 32'd500);
    drive(2'b10, 2'b00, 16'd0, 16'd0, 16'd164, 16'd164);
    @(negedge clk);
    chk("cut_regrant1", 32'(bus.req_ready), 32'h2);
    for (int b = 64; b < 100; b++) begin
      drive(2'b10, 2'b00, 16'd0, 16'd0, 16'(100 + b), 16'(100 + b));
      @(negedge clk);
      chk($sformatf("cut2_en%0d", b), 32'(bus.ctrl_en), 32'h1);
      chk($sformatf("cut2_addr%0d", b), 32'(bus.ctrl_addr), 32'(100 + b));
      chk($sformatf("cut2_rdy%0d", b), 32'(bus.req_ready), 32'h2);
    end

    // Timeout: owner 0 stalls after 3 beats; grant revoked after 16 stalled cycles.
    do_reset();
    drive(2'b11, 2'b10, 16'h300, 16'h300, 16'h700, 16'h700);
    @(negedge clk);
    chk("to_grant0", 32'(bus.req_ready), 32'h1);
    for (int b = 0; b < 3; b++) begin
      a = 16'(16'h300 + b);
      drive(2'b11, 2'b10, a, a, 16'h700, 16'h700);
      @(negedge clk);
    end
    drive(2'b10, 2'b10, 16'd0, 16'd0, 16'h700, 16'h700);
    stall = 0;
    guard = 0;
    while (bus.req_ready == 2'b01 && guard < 40) begin
      stall++;
      guard++;
      @(negedge clk);
    end
    chk("to_stall_cycles", 32'(stall), 32'd16);
    chk("to_idle", 32'(bus.req_ready), 32'h0);
    @(negedge clk);
    chk("to_grant1", 32'(bus.req_ready), 32'h2);
    chk("to_gid", 32'(grant_id), 32'h1);

    // Reset at beat 10 of a requester-1 burst.
    do_reset();
    drive(2'b10, 2'b00, 16'd0, 16'd0, 16'h40, 16'h40);
    @(negedge clk);
    chk("rst_grant1", 32'(bus.req_ready), 32'h2);
    for (int b = 0; b < 10; b++) begin
      drive(2'b10, 2'b00, 16'd0, 16'd0, 16'(16'h40 + b), 16'(16'h40 + b));
      @(negedge clk);
    end
    chk("rst_pre_en", 32'(bus.ctrl_en), 32'h1);
    chk("rst_pre_addr", 32'(bus.ctrl_addr), 32'h49);
    drive(2'b11, 2'b00, 16'h55, 16'h55, 16'h4A, 16'h4A);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_en", 32'(bus.ctrl_en), 32'h0);
    chk("rst_addr", 32'(bus.ctrl_addr), 32'h0);
    chk("rst_wdat", 32'(bus.ctrl_wdat), 32'h0);
    chk("rst_rdy", 32'(bus.req_ready), 32'h0);
    chk("rst_gid", 32'(grant_id), 32'h0);
    chk("rst_drop", 32'(drop_pulse), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_first_grant", 32'(bus.req_ready), 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end
endmodule
